// File: rtl/car_pkg.sv
// ============================================================================
// Module  : car_pkg
// Brief   : Shared drive constants and ramp state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package car_pkg;

  localparam int PWM_PERIOD = 400000;
  localparam int MIN_DUTY   = 128;
  localparam int MAX_DUTY   = 230;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_ESTOP = 2'd3
  } ramp_state_t;

  function automatic logic [7:0] clamp_duty(input logic [7:0] d, input logic [7:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module  : tick_gen
// Brief   : Free-running 0..TICK_CYCLES-1 counter with a one-cycle wrap pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_CYCLES = 400000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == c_LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/duty_ramp.sv
// ============================================================================
// Module  : duty_ramp
// Brief   : Slew-limits PWM duty toward a commanded target, with e-stop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_ramp #(
  parameter int TICK_CYCLES = car_pkg::PWM_PERIOD,
  parameter int STEP        = 4,
  parameter int MAX_DUTY    = car_pkg::MAX_DUTY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_duty,
  output logic       cmd_ready,
  input  logic       estop,
  input  logic       estop_clr,
  output logic [7:0] duty,
  output logic       at_target,
  output logic       estop_active
);

  import car_pkg::*;

  localparam logic [7:0] c_STEP = 8'(STEP);
  localparam logic [7:0] c_MAX  = 8'(MAX_DUTY);

  ramp_state_t r_state, w_state_nxt;
  logic [7:0]  r_duty, w_duty_nxt;
  logic [7:0]  r_target, w_target_nxt;
  logic        w_tick;
  logic        w_accept;
  logic [8:0]  w_up_sum;
  logic [7:0]  w_up_val;
  logic [7:0]  w_dn_gap;
  logic [7:0]  w_dn_val;

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign cmd_ready = (r_state != S_ESTOP) && !estop;
  assign w_accept  = cmd_valid && cmd_ready;

  // Up step formed one bit wide so a sum past 255 still saturates at target.
  assign w_up_sum = {1'b0, r_duty} + {1'b0, c_STEP};
  assign w_up_val = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[7:0];

  // Gap is only meaningful when duty is above target (DOWN with a stable target).
  assign w_dn_gap = r_duty - r_target;
  assign w_dn_val = (w_dn_gap > c_STEP) ? (r_duty - c_STEP) : r_target;

  always_comb begin
    w_state_nxt  = r_state;
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;

    if (w_accept) begin
      w_target_nxt = clamp_duty(cmd_duty, c_MAX);
    end

    case (r_state)
      S_HOLD: begin
        if (r_target > r_duty) begin
          w_state_nxt = S_UP;
        end else if (r_target < r_duty) begin
          w_state_nxt = S_DOWN;
        end
      end
      S_UP: begin
        if (r_target < r_duty) begin
          w_state_nxt = S_DOWN;
        end else if (r_target == r_duty) begin
          w_state_nxt = S_HOLD;
        end else if (w_tick) begin
          w_duty_nxt = w_up_val;
          if (w_up_val == r_target) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_DOWN: begin
        if (r_target > r_duty) begin
          w_state_nxt = S_UP;
        end else if (r_target == r_duty) begin
          w_state_nxt = S_HOLD;
        end else if (w_tick) begin
          w_duty_nxt = w_dn_val;
          if (w_dn_val == r_target) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_ESTOP: begin
        if (estop_clr && !estop) begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase

    // Emergency stop overrides everything above, including a same-cycle command.
    if (estop && (r_state != S_ESTOP)) begin
      w_state_nxt  = S_ESTOP;
      w_duty_nxt   = 8'd0;
      w_target_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HOLD;
      r_duty   <= 8'd0;
      r_target <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_duty   <= w_duty_nxt;
      r_target <= w_target_nxt;
    end
  end

  assign duty         = r_duty;
  assign at_target    = (r_state == S_HOLD);
  assign estop_active = (r_state == S_ESTOP);

endmodule

`default_nettype wire

// File: tb/tb_duty_ramp.sv
// ============================================================================
// Module  : tb_duty_ramp
// Brief   : Scoreboard bench for duty_ramp with a behavioural slew model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_duty_ramp;

  localparam int TICK = 10;
  localparam int STP  = 4;
  localparam int MAXD = 230;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_ready;
  logic       estop = 1'b0;
  logic       estop_clr = 1'b0;
  logic [7:0] duty;
  logic       at_target;
  logic       estop_active;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int duty;
    bit at_t;
    bit est;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: duty/target as integers, direction as a sign
  int m_duty = 0;
  int m_tgt  = 0;
  int m_dir  = 0;
  int m_cnt  = 0;
  bit m_est  = 1'b0;

  duty_ramp #(
    .TICK_CYCLES (TICK),
    .STEP        (STP),
    .MAX_DUTY    (MAXD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_duty     (cmd_duty),
    .cmd_ready    (cmd_ready),
    .estop        (estop),
    .estop_clr    (estop_clr),
    .duty         (duty),
    .at_target    (at_target),
    .estop_active (estop_active)
  );

  always #5 clk = ~clk;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one expectation per clock edge; asynchronous reset flushes it.
  initial begin
    exp_t e;
    bit   tk;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_duty = 0; m_tgt = 0; m_dir = 0; m_cnt = 0; m_est = 1'b0;
        exp_q.delete();
      end else begin
        tk    = (m_cnt == TICK - 1);
        m_cnt = (m_cnt + 1) % TICK;
        if (!m_est && estop) begin
          m_duty = 0; m_tgt = 0; m_est = 1'b1; m_dir = 0;
        end else if (m_est) begin
          if (estop_clr && !estop) m_est = 1'b0;
          m_dir = 0;
        end else begin
          if (tk && m_dir != 0 && sgn(m_tgt - m_duty) == m_dir) begin
            m_duty = (m_dir > 0) ? imin(m_duty + STP, m_tgt) : imax(m_duty - STP, m_tgt);
          end
          m_dir = sgn(m_tgt - m_duty);
          if (cmd_valid) m_tgt = imin(int'(cmd_duty), MAXD);
        end
      end
      e.duty = m_duty;
      e.at_t = !m_est && (m_dir == 0);
      e.est  = m_est;
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_duty", int'(duty), e.duty);
        chk("sb_at_target", int'(at_target), int'(e.at_t));
        chk("sb_estop_active", int'(estop_active), int'(e.est));
        chk("sb_cmd_ready", int'(cmd_ready), int'(!e.est && !estop));
      end
    end
  end

  task automatic step(input bit v, input int d, input bit e, input bit c);
    @(posedge clk);
    #2;
    cmd_valid = v;
    cmd_duty  = 8'(d);
    estop     = e;
    estop_clr = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_duty(input int val, input int budget, input string name);
    int k;
    k = 0;
    while (int'(duty) != val && k < budget) begin
      step(1'b0, 0, 1'b0, 1'b0);
      k++;
    end
    chk(name, int'(duty), val);
  endtask

  initial begin
    int first;

    // Reset
    idle(3);
    chk("rst_duty", int'(duty), 0);
    chk("rst_at_target", int'(at_target), 1);
    chk("rst_estop_active", int'(estop_active), 0);
    @(posedge clk); #2; rst_n = 1'b1;

    // Ramp 0 -> 20 in steps of 4
    step(1'b1, 20, 1'b0, 1'b0);
    wait_duty(4, 15, "up_4");
    wait_duty(8, 15, "up_8");
    wait_duty(12, 15, "up_12");
    wait_duty(16, 15, "up_16");
    wait_duty(20, 15, "up_20");
    chk("up_20_hold", int'(at_target), 1);

    // Emergency stop mid-period during a ramp at 40
    step(1'b1, 100, 1'b0, 1'b0);
    wait_duty(40, 60, "es_reach_40");
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 100, 1'b1, 1'b0);
    chk("es_duty0", int'(duty), 0);
    chk("es_active", int'(estop_active), 1);
    chk("es_ready_low", int'(cmd_ready), 0);
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("es_clr_ignored", int'(estop_active), 1);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("es_left", int'(estop_active), 0);
    chk("es_hold", int'(at_target), 1);
    idle(25);
    chk("es_duty_stays0", int'(duty), 0);

    // Clamp to MAX_DUTY with truncated last step
    step(1'b1, 255, 1'b0, 1'b0);
    wait_duty(228, 700, "clamp_228");
    wait_duty(230, 15, "clamp_230");
    chk("clamp_hold", int'(at_target), 1);
    idle(25);
    chk("clamp_no_exceed", int'(duty), 230);

    // Down to 10, then 10 -> 6 -> 3
    step(1'b1, 10, 1'b0, 1'b0);
    wait_duty(10, 700, "down_10");
    idle(1);
    chk("down_10_hold", int'(at_target), 1);
    step(1'b1, 3, 1'b0, 1'b0);
    wait_duty(6, 15, "down_6");
    wait_duty(3, 15, "down_3");
    idle(1);
    chk("down_3_hold", int'(at_target), 1);

    // Retarget while ramping up: 60 heading to 100, new target 50
    step(1'b1, 0, 1'b0, 1'b0);
    wait_duty(0, 15, "down_0");
    step(1'b1, 100, 1'b0, 1'b0);
    wait_duty(60, 200, "rt_reach_60");
    step(1'b1, 50, 1'b0, 1'b0);
    wait_duty(56, 15, "rt_56");
    wait_duty(52, 15, "rt_52");
    wait_duty(50, 15, "rt_50");
    idle(1);
    chk("rt_hold", int'(at_target), 1);

    // Reset mid-ramp, then time the first tick after release
    step(1'b1, 200, 1'b0, 1'b0);
    wait_duty(62, 40, "mr_reach_62");
    @(posedge clk); #2;
    rst_n = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("mr_duty", int'(duty), 0);
    chk("mr_at_target", int'(at_target), 1);
    chk("mr_estop_active", int'(estop_active), 0);
    idle(2);
    @(posedge clk); #2;
    rst_n = 1'b1; cmd_valid = 1'b1; cmd_duty = 8'd40;
    first = -1;
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 0, 1'b0, 1'b0);
      if (first < 0 && duty == 8'd4) first = k;
    end
    chk("mr_first_tick", first, 10);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 2) begin
        step(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end else begin
        step(($urandom_range(0, 99) < 8), int'($urandom_range(0, 255)),
             ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10));
      end
    end
    idle(4);

    n_tests++;
    if (n_tests < 1000) begin
      n_fail++;
      $display("FAIL sb_activity: got %0d comparisons expected at least 1000", n_tests);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter TICK_CYCLES, default 400000, clock cycles per ramp step; equals one PWM period of the downstream generator.
REQ-002 Parameter STEP, default 4, duty change per tick in 1/256 units; legal range 1..255.
REQ-003 Parameter MAX_DUTY, default 230, ceiling applied to accepted targets (about 90% of 256).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  input  1  new target duty offered.
REQ-007 cmd_duty  input  8  requested target duty, 0..255.
REQ-008 cmd_ready  output  1  block can accept a command this cycle.
REQ-009 estop  input  1  bumper emergency stop, level, already synchronised to clk.
REQ-010 estop_clr  input  1  single-cycle request to leave emergency stop.
REQ-011 duty  output  8  registered duty command to the PWM generator.
REQ-012 at_target  output  1  high when duty equals the accepted target and not in ESTOP.
REQ-013 estop_active  output  1  high while in ESTOP state.

Function
REQ-014 Free-running tick counter SHALL count 0..TICK_CYCLES-1 and wrap; tick pulses for one cycle when count == TICK_CYCLES-1; counter is unaffected by commands or estop.
REQ-015 Command SHALL be accepted when cmd_valid && cmd_ready; target <= min(cmd_duty, MAX_DUTY) on that edge.
REQ-016 cmd_ready SHALL equal (state != ESTOP) && !estop, combinationally.
REQ-017 States: HOLD, UP, DOWN, ESTOP; one-hot or binary encoding is implementation choice.
REQ-018 HOLD -> UP when target > duty; HOLD -> DOWN when target < duty; evaluated every cycle against the registered target.
REQ-019 On tick in UP: duty <= min(duty + STEP, target), sum formed at 9 bits, no wrap; go to HOLD when result == target.
REQ-020 On tick in DOWN: duty <= max(duty - STEP, target), compare before subtract, no underflow; go to HOLD when result == target.
REQ-021 duty SHALL change only on tick, except on ESTOP entry.
REQ-022 A new command accepted mid-ramp retargets; direction is re-evaluated the following cycle (UP may go directly to DOWN or HOLD).
REQ-023 estop high in any non-ESTOP state: next edge duty <= 0, target <= 0, state <= ESTOP, no tick wait.
REQ-024 estop and accepted command in the same cycle: estop wins; the command is discarded (cmd_ready is already low).
REQ-025 ESTOP -> HOLD only when estop_clr && !estop; duty stays 0 until a new command arrives; estop_clr in any other state is ignored.
REQ-026 at_target SHALL be registered-state derived: (state == HOLD).

Reset
REQ-027 rst_n low: duty = 0, target = 0, tick counter = 0, state = HOLD, at_target = 1, estop_active = 0, asynchronously.
REQ-028 Reset mid-ramp SHALL abandon the ramp; no pending command survives reset.
REQ-029 Deassertion SHALL be synchronous to clk upstream; the first tick fires TICK_CYCLES cycles after release.

Structure
REQ-030 Shared package car_pkg SHALL hold the state enum, PWM_PERIOD (400000), and duty limits MIN_DUTY (128) and MAX_DUTY (230), also used by pwm_gen.
REQ-031 The tick counter SHALL be a separate sub-module tick_gen(clk, rst_n, tick) parameterised by TICK_CYCLES.
REQ-032 Counter width SHALL be $clog2(TICK_CYCLES); no other arithmetic wider than 9 bits.

Verification (bench uses TICK_CYCLES=10, STEP=4)
REQ-033 Reset, then cmd_duty=20 -> duty 4,8,12,16,20 on five consecutive ticks; at_target high after the fifth tick.
REQ-034 cmd_duty=255 -> target clamps to 230; duty reaches 230 and never exceeds it; the last step is truncated from 228 to 230.
REQ-035 At duty=10 with target 10, cmd_duty=3 -> duty 6 then 3; no underflow; HOLD after the second tick.
REQ-036 Ramp at duty=40, estop high mid-period -> duty=0 next cycle; cmd_valid ignored with cmd_ready=0; estop_clr while estop=1 ignored; estop low + estop_clr -> HOLD with duty 0.
REQ-037 While ramping up to 100, at duty=60, cmd_duty=50 -> next ticks give duty 56, then 52, then 50; HOLD follows.
REQ-038 rst_n pulsed low mid-ramp -> all outputs reach reset values immediately; first tick occurs 10 cycles after release.
